ip_one_port_ram: RTL and testbench
==================================

# ip_one_port_ram

Self-exercising single-port RAM block: an on-chip 32×8 synchronous single-port memory plus a built-in read/write sequencer that continuously fills the memory with a known pattern, reads it back and flags mismatches. It is a standalone demonstration/qualification block for the RAM IP, driven only by the board clock and reset. All other signals are exposed as observation outputs for debug and verification.

## Interface
- DATA_W, 8, RAM word width
- DEPTH, 32, number of RAM words
- ADDR_W, 5, address width (log2(DEPTH))
- sys_clk  input  1  system clock, 50 MHz (20 ns period); all logic on rising edge
- sys_rst_n  input  1  asynchronous, active-high reset (asserted = 1 despite the suffix); release synchronous to sys_clk
- ram_wr_en  output  1  write strobe to RAM
- ram_rd_en  output  1  read strobe to RAM
- ram_addr  output  ADDR_W  shared RAM address
- ram_wr_data  output  DATA_W  write data
- ram_rd_data  output  DATA_W  registered read data
- err  output  1  sticky mismatch flag

## Operation
- Free-running 6-bit sequence counter rw_cnt, 0..2*DEPTH-1, wraps to 0.
- Write phase, rw_cnt 0..31: ram_wr_en=1, ram_rd_en=0, ram_addr=rw_cnt[4:0], ram_wr_data=rw_cnt[4:0] zero-extended to DATA_W.
- Read phase, rw_cnt 32..63: ram_wr_en=0, ram_rd_en=1, ram_addr=rw_cnt-32, ram_wr_data=0.
- Control outputs are combinational decodes of rw_cnt, so they change once per clock.
- RAM: write on a clock edge with wr_en; on rd_en, ram_rd_data <= mem[addr]. When rd_en=0, ram_rd_data holds its value (no-change mode). Write and read are never asserted together.
- Checker: one cycle after each read strobe, compare ram_rd_data to the address read; on mismatch set err=1. err clears only on reset.
- Reset: rw_cnt=0, ram_rd_data=0, err=0; memory array is NOT reset (contents persist). Reset mid-sequence restarts at write phase, address 0; because every word is rewritten before being read, err never fires because of reset.

## Timing
- Reset release edge E0: cycle k (0..31) writes mem[k]=k.
- Cycle 32+k issues read of addr k; ram_rd_data=k valid from cycle 33+k; read latency 1 clock.
- ram_rd_data=31 valid at cycle 64, coinciding with the next write phase (holds since rd_en=0).
- Full period 64 clocks = 1.28 µs; repeats indefinitely.
- Checker compare enable is rd_en delayed one cycle; expected value is ram_addr delayed one cycle.
- Address wrap: 31→0 between phases; rw_cnt 63→0.

## Structure
- Package ip_one_port_ram_pkg: DATA_W, DEPTH, ADDR_W, phase boundary constant (DEPTH).
- Sub-module ip_one_port_ram_spram: synchronous single-port RAM (clk, wr_en, rd_en, addr, wr_data, rd_data); inferrable as block RAM, replaceable by vendor IP.
- Top holds counter, decode, checker.

## Test plan
- Reset held 200 ns, released -> all outputs 0 during reset; first write (addr 0, data 0) in the cycle after release.
- Write phase -> 32 consecutive cycles of ram_wr_en=1 with addr=data=0..31; ram_rd_en=0 throughout.
- Read phase -> ram_rd_data sequence 0,1,...,31 one cycle behind addresses 0..31; err stays 0 over ≥3 full periods.
- Fault injection (force mem[7]=8'hAA via hierarchy before read phase) -> err=1 one cycle after the read of addr 7, stays 1 until reset.
- Reset asserted at rw_cnt=45 for 3 cycles -> rw_cnt returns to 0, err=0, rd_data=0; next read phase returns 0..31 with err=0.
- Hold check: during write phase ram_rd_data stays at 31 (last read value) after the first period.

Source files
------------

// File: rtl/ip_one_port_ram_pkg.sv
// ----------------------------------------------------------------------------
// ip_one_port_ram_pkg
// Shared parameters and types for the self-exercising single-port RAM block.
//   DATA_W      : RAM word width
//   DEPTH       : number of RAM words
//   ADDR_W      : address width, log2(DEPTH)
//   CNT_W       : sequence counter width, spans one write and one read phase
//   PHASE_BOUND : first counter value of the read phase
// ----------------------------------------------------------------------------
package ip_one_port_ram_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned DEPTH       = 32;
   localparam int unsigned ADDR_W      = $clog2(DEPTH);
   localparam int unsigned CNT_W       = ADDR_W + 1;
   localparam int unsigned PHASE_BOUND = DEPTH;

   typedef enum logic {
      PH_WRITE = 1'b0,
      PH_READ  = 1'b1
   } phase_t;

   // Pattern stored at each address: the address itself, zero-extended.
   function automatic logic [DATA_W-1:0] addr_pattern(input logic [ADDR_W-1:0] a);
      return DATA_W'(a);
   endfunction

endpackage

// File: rtl/ip_one_port_ram_spram.sv
// ----------------------------------------------------------------------------
// ip_one_port_ram_spram
// Synchronous single-port RAM, read-first/no-change output register.
// Inferrable as block RAM; can be swapped for a vendor macro.
//   clk     : clock, all activity on rising edge
//   rst     : async active-high reset of the read-data register only
//   wr_en   : write strobe, mem[addr] <= wr_data
//   rd_en   : read strobe, rd_data <= mem[addr] (holds when low)
//   addr    : shared address
//   wr_data : write data
//   rd_data : registered read data, 1-clock latency
// ----------------------------------------------------------------------------
module ip_one_port_ram_spram
   import ip_one_port_ram_pkg::*;
#(
   parameter int unsigned WORD_W = DATA_W,
   parameter int unsigned WORDS  = DEPTH,
   parameter int unsigned AW     = ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wr_data,
   output logic [WORD_W-1:0] rd_data
);

   // Array deliberately has no reset so it maps onto block RAM.
   logic [WORD_W-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[addr];
      end
   end

endmodule

// File: rtl/ip_one_port_ram.sv
// ----------------------------------------------------------------------------
// ip_one_port_ram
// Self-exercising single-port RAM: a free-running sequencer writes the
// address pattern to every word, reads all words back, and raises a sticky
// error flag on any mismatch. Period is 2*DEPTH clocks, repeating forever.
//   sys_clk     : system clock
//   sys_rst_n   : async reset, ACTIVE HIGH despite the name
//   ram_wr_en   : RAM write strobe (write phase)
//   ram_rd_en   : RAM read strobe (read phase)
//   ram_addr    : RAM address
//   ram_wr_data : RAM write data (address pattern in write phase, else 0)
//   ram_rd_data : registered RAM read data
//   err         : sticky mismatch flag, cleared only by reset
// ----------------------------------------------------------------------------
module ip_one_port_ram
   import ip_one_port_ram_pkg::*;
(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   output logic              ram_wr_en,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic [DATA_W-1:0] ram_rd_data,
   output logic              err
);

   logic [CNT_W-1:0]  rw_cnt;
   phase_t            phase;
   logic              chk_en;
   logic [ADDR_W-1:0] chk_addr;

   // Sequence counter: 0..2*DEPTH-1, then wraps.
   always_ff @(posedge sys_clk or posedge sys_rst_n) begin
      if (sys_rst_n) begin
         rw_cnt <= '0;
      end else if (rw_cnt == CNT_W'(2 * DEPTH - 1)) begin
         rw_cnt <= '0;
      end else begin
         rw_cnt <= rw_cnt + CNT_W'(1);
      end
   end

   // Control decode. Strobes are held low while reset is asserted so that
   // no write lands in the array and all outputs read 0 during reset; the
   // first write (addr 0) is issued in the cycle after release.
   always_comb begin
      phase       = (rw_cnt >= CNT_W'(PHASE_BOUND)) ? PH_READ : PH_WRITE;
      ram_wr_en   = 1'b0;
      ram_rd_en   = 1'b0;
      ram_addr    = '0;
      ram_wr_data = '0;
      if (!sys_rst_n) begin
         case (phase)
            PH_WRITE: begin
               ram_wr_en   = 1'b1;
               ram_addr    = rw_cnt[ADDR_W-1:0];
               ram_wr_data = addr_pattern(rw_cnt[ADDR_W-1:0]);
            end
            PH_READ: begin
               ram_rd_en   = 1'b1;
               ram_addr    = ADDR_W'(rw_cnt - CNT_W'(PHASE_BOUND));
            end
            default: ;
         endcase
      end
   end

   ip_one_port_ram_spram #(
      .WORD_W (DATA_W),
      .WORDS  (DEPTH),
      .AW     (ADDR_W)
   ) u_ram (
      .clk     (sys_clk),
      .rst     (sys_rst_n),
      .wr_en   (ram_wr_en),
      .rd_en   (ram_rd_en),
      .addr    (ram_addr),
      .wr_data (ram_wr_data),
      .rd_data (ram_rd_data)
   );

   // Checker: read strobe and address delayed one cycle line up with the
   // registered read data.
   always_ff @(posedge sys_clk or posedge sys_rst_n) begin
      if (sys_rst_n) begin
         chk_en   <= 1'b0;
         chk_addr <= '0;
         err      <= 1'b0;
      end else begin
         chk_en   <= ram_rd_en;
         chk_addr <= ram_addr;
         if (chk_en && (ram_rd_data != addr_pattern(chk_addr))) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ip_one_port_ram.sv
module tb_ip_one_port_ram;

   logic       clk;
   logic       rst;
   logic       ram_wr_en;
   logic       ram_rd_en;
   logic [4:0] ram_addr;
   logic [7:0] ram_wr_data;
   logic [7:0] ram_rd_data;
   logic       err;

   typedef struct packed {
      logic [7:0] data;
      logic       bad;
   } exp_t;

   exp_t exp_q [$];

   int vec;
   int miss;
   int n;          // clocks since last reset release
   logic err_exp;
   logic err_arm;
   logic rd_prev;
   logic [7:0] last_rd;

   ip_one_port_ram dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst),
      .ram_wr_en   (ram_wr_en),
      .ram_rd_en   (ram_rd_en),
      .ram_addr    (ram_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_data (ram_rd_data),
      .err         (err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) n <= 0;
      else     n <= n + 1;
   end

   task automatic check(input string name, input int act, input int req);
      vec++;
      if (act != req) begin
         miss++;
         $display("FAIL %s at t=%0t n=%0d: got 0x%0h, expected 0x%0h", name, $time, n, act, req);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         check("reset_outputs",
               int'({ram_wr_en, ram_rd_en, ram_addr, ram_wr_data, ram_rd_data, err}), 0);
         exp_q.delete();
         err_exp = 1'b0;
         err_arm = 1'b0;
         rd_prev = 1'b0;
         last_rd = 8'h00;
      end else begin
         int unsigned m;
         logic        ew;
         logic [14:0] ctrl_exp;
         exp_t        e;
         if (err_arm) err_exp = 1'b1;
         err_arm = 1'b0;
         m  = n % 64;
         ew = (m < 32);
         ctrl_exp = {ew, !ew, 5'(m % 32), ew ? 8'(m % 32) : 8'h00};
         check("control", int'({ram_wr_en, ram_rd_en, ram_addr, ram_wr_data}), int'(ctrl_exp));
         if (rd_prev) begin
            if (exp_q.size() == 0) begin
               check("rd_data_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("rd_data", int'(ram_rd_data), int'(e.data));
               last_rd = e.data;
               if (e.bad) err_arm = 1'b1;
            end
         end else begin
            check("rd_hold", int'(ram_rd_data), int'(last_rd));
         end
         check("err", int'(err), int'(err_exp));
         rd_prev = ram_rd_en;
      end
   end

   task automatic push_period(input logic inject);
      exp_t e;
      for (int unsigned a = 0; a < 32; a++) begin
         e.data = 8'(a);
         e.bad  = 1'b0;
         if (inject && a == 7) begin
            e.data = 8'hAA;
            e.bad  = 1'b1;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_n(input int target);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (n == target) break;
      end
      if (n != target) check("wait_timeout", n, target);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec  = 0;
      miss = 0;
      rst  = 1'b1;
      #200;
      @(posedge clk);
      #1 rst = 1'b0;

      // Periods 0..2 clean, period 3 carries an injected fault at addr 7,
      // period 4 clean (mem[7] rewritten) with err still sticky.
      push_period(1'b0);
      push_period(1'b0);
      push_period(1'b0);
      push_period(1'b1);
      push_period(1'b0);

      wait_n(3 * 64 + 10);
      dut.u_ram.mem[7] = 8'hAA;

      wait_n(5 * 64);
      push_period(1'b0);

      // Mid-sequence reset at rw_cnt = 45 for 3 clocks.
      wait_n(5 * 64 + 45);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      push_period(1'b0);
      push_period(1'b0);

      wait_n(2 * 64 + 2);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) check("drain", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
